mem_scan_streamer: RTL and testbench



---
 rtl/mem_scan_streamer_pkg.sv | 20 ++
 rtl/mem_scan_streamer_if.sv | 18 +
 rtl/mem_scan_streamer_skid.sv | 45 ++++
 rtl/mem_scan_streamer.sv | 111 +++++++++++
 tb/tb_mem_scan_streamer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_scan_streamer_pkg.sv
// Shared types and helpers for the memory scan streamer.
// Holds the FSM state encoding and the signature update step.
package mem_scan_pkg;

  localparam int SIG_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  // Rotate left by one, then fold in the zero-extended word.
  function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                input logic [SIG_W-1:0] word);
    return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ word;
  endfunction

endpackage

// File: rtl/mem_scan_streamer_if.sv
// RAM read port plus the output word stream of the scan streamer.
// master = streamer side, slave = RAM/consumer side.
interface mem_scan_streamer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 18
);
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (output raddr, out_valid, out_data, out_last,
                  input  rdata, out_ready);
  modport slave  (input  raddr, out_valid, out_data, out_last,
                  output rdata, out_ready);
endinterface

// File: rtl/mem_scan_streamer_skid.sv
// Two-entry FIFO of {last, data} feeding the output stream.
// Flush empties it in one cycle and wins over a same-cycle push.
module mem_scan_skid #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         push_last,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic         head_last,
  output logic [W-1:0] head_data,
  output logic [1:0]   occ
);
  logic [1:0][W:0] mem;
  logic            wr_ptr, rd_ptr;
  logic            do_pop;

  assign do_pop = pop && (occ != 2'd0);
  assign valid  = (occ != 2'd0);
  assign {head_last, head_data} = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/mem_scan_streamer.sv
// Sweeps an inclusive RAM address range, streams the words in order and
// keeps a rolling signature plus accepted-word count for readback checks.
module mem_scan_streamer
  import mem_scan_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 18,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  mem_scan_streamer_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              range_err,
  output logic [ADDR_W:0]   word_count,
  output logic [SIG_W-1:0]  signature
);
  scan_state_t       state;
  logic [ADDR_W-1:0] cnt, end_r;
  logic              inflight, inflight_last;
  logic [1:0]        occ;
  logic [2:0]        room;
  logic              pop, issue, issue_last, flush;

  assign busy       = (state == SCAN) || (state == DRAIN);
  assign pop        = bus.out_valid & bus.out_ready;
  assign flush      = busy & abort;
  assign bus.raddr  = cnt;

  // Reserve a buffer slot for every read in flight so rdata is never dropped.
  assign room       = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign issue      = (state == SCAN) && !abort && (room < 3'(BUF_DEPTH));
  assign issue_last = issue && (cnt == end_r);

  mem_scan_skid #(.W(DATA_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (inflight),
    .push_last (inflight_last),
    .push_data (bus.rdata),
    .pop       (pop),
    .valid     (bus.out_valid),
    .head_last (bus.out_last),
    .head_data (bus.out_data),
    .occ       (occ)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      end_r         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      range_err     <= 1'b0;
      word_count    <= '0;
      signature     <= '0;
    end else begin
      done          <= 1'b0;
      aborted       <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue_last;
      if (pop) begin
        signature  <= sig_step(signature, 32'(bus.out_data));
        word_count <= word_count + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          end_r      <= end_addr;
          signature  <= '0;
          word_count <= '0;
          range_err  <= (end_addr < start_addr);
          if (end_addr < start_addr) begin
            state <= DONE;
          end else begin
            cnt   <= start_addr;
            state <= SCAN;
          end
        end
        SCAN: if (abort) begin
          state   <= IDLE;
          aborted <= 1'b1;
        end else if (issue) begin
          // Counter parks on end_addr so a top-of-memory range never wraps.
          if (issue_last) state <= DRAIN;
          else            cnt   <= cnt + 1'b1;
        end
        DRAIN: if (abort) begin
          state   <= IDLE;
          aborted <= 1'b1;
        end else if (occ == 2'd0 && !inflight && !pop) begin
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_scan_streamer.sv
// Scoreboarded bench: RAM model feeds the DUT, expected words are queued at
// start and checked in order at every accepted transfer.
module tb_mem_scan_streamer;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 18;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0, abort = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0, end_addr = '0;
  logic              busy, done, aborted, range_err;
  logic [ADDR_W:0]   word_count;
  logic [31:0]       signature;

  mem_scan_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_scan_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr), .bus(bus),
    .busy(busy), .done(done), .aborted(aborted), .range_err(range_err),
    .word_count(word_count), .signature(signature)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) bus.rdata <= ram[bus.raddr];

  int n_tests = 0, n_fail = 0;
  logic [DATA_W:0] exp_q[$];
  logic [31:0]     exp_sig;
  int              exp_cnt;
  int              done_seen = 0;

  // Scoreboard: every accepted word must match the queue head.
  always @(negedge clk) begin
    if (reset) begin
      if (done) done_seen++;
      if (bus.out_valid && bus.out_ready) begin
        logic [DATA_W:0] e, g;
        g = {bus.out_last, bus.out_data};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: got %h, expected no word", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            n_fail++;
            $display("FAIL sb_word: got %h, expected %h", g, e);
          end
        end
        exp_sig = {exp_sig[30:0], exp_sig[31]} ^ {14'd0, bus.out_data};
        exp_cnt++;
      end
    end
  end

  task automatic push_range(input int s, input int e);
    exp_sig = 32'd0;
    exp_cnt = 0;
    for (int a = s; a <= e; a++) exp_q.push_back({(a == e), ram[a]});
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
    @(posedge clk); #1;
    start = 1'b1; start_addr = s; end_addr = e;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    n_tests++;
    if (k == budget) begin
      n_fail++;
      $display("FAIL %s_done_timeout: done not seen in %0d cycles", name, budget);
    end
  endtask

  task automatic check_end(input string name, input int cnt, input logic [31:0] sig);
    n_tests++;
    if (word_count !== (ADDR_W+1)'(cnt)) begin
      n_fail++; $display("FAIL %s_count: got %0d, expected %0d", name, word_count, cnt);
    end
    n_tests++;
    if (signature !== sig) begin
      n_fail++; $display("FAIL %s_sig: got %h, expected %h", name, signature, sig);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL %s_missing: %0d words not delivered, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({bus.out_valid, busy, done, aborted, range_err} !== 5'b0 ||
        word_count !== '0 || signature !== 32'd0 || bus.raddr !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b cnt=%0d sig=%h raddr=%h, expected all 0",
               bus.out_valid, busy, done, word_count, signature, bus.raddr);
    end
  endtask

  task automatic test_scan_basic();
    int d0;
    push_range(0, 3);
    bus.out_ready = 1'b1;
    d0 = done_seen;
    do_start(12'd0, 12'd3);
    for (int c = 1; c <= 7; c++) begin
      logic [1:0] exp_vl;
      @(negedge clk);
      exp_vl = {(c >= 3 && c <= 6), (c == 6)};
      n_tests++;
      if ({bus.out_valid, bus.out_valid & bus.out_last} !== exp_vl) begin
        n_fail++;
        $display("FAIL basic_timing c%0d: valid/last=%b, expected %b", c,
                 {bus.out_valid, bus.out_valid & bus.out_last}, exp_vl);
      end
    end
    wait_done(20, "basic");
    check_end("basic", 4, 32'h0000_0003);
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || done_seen - d0 != 1) begin
      n_fail++; $display("FAIL basic_done_pulse: pulses=%0d, expected 1", done_seen - d0);
    end
  endtask

  task automatic test_single_word();
    ram[12'h7FF] = 18'h2AAAA;
    push_range(12'h7FF, 12'h7FF);
    do_start(12'h7FF, 12'h7FF);
    wait_done(20, "single");
    check_end("single", 1, 32'h0002_AAAA);
  endtask

  task automatic test_top_of_memory();
    push_range(12'hFFE, 12'hFFF);
    do_start(12'hFFE, 12'hFFF);
    wait_done(20, "top");
    check_end("top", 2, exp_sig);
    n_tests++;
    if (bus.raddr !== 12'hFFF) begin
      n_fail++; $display("FAIL top_nowrap: raddr=%h, expected fff", bus.raddr);
    end
  endtask

  task automatic test_backpressure();
    logic stall_bad = 1'b0, got_done = 1'b0;
    int   max_occ = 0;
    push_range(0, 15);
    bus.out_ready = 1'b1;
    do_start(12'd0, 12'd15);
    for (int c = 1; c <= 60 && !got_done; c++) begin
      bus.out_ready = !(c >= 4 && c <= 13);
      @(negedge clk);
      if (c >= 5 && c <= 13 && bus.raddr !== 12'd3) stall_bad = 1'b1;
      if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
      if (done) got_done = 1'b1;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    n_tests++;
    if (!got_done) begin n_fail++; $display("FAIL bp_done: done not seen, expected 1"); end
    n_tests++;
    if (stall_bad) begin n_fail++; $display("FAIL bp_stall: raddr moved, expected held at 3"); end
    n_tests++;
    if (max_occ > 2) begin n_fail++; $display("FAIL bp_occ: max=%0d, expected <=2", max_occ); end
    check_end("bp", 16, exp_sig);
  endtask

  task automatic test_range_err();
    logic seen_bad = 1'b0;
    push_range(1, 0);
    do_start(12'd5, 12'd2);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (bus.out_valid || busy) seen_bad = 1'b1;
      n_tests++;
      if (done !== (c == 2)) begin
        n_fail++; $display("FAIL rerr_done c%0d: done=%b, expected %b", c, done, (c == 2));
      end
    end
    n_tests++;
    if (seen_bad) begin n_fail++; $display("FAIL rerr_activity: valid/busy seen, expected none"); end
    n_tests++;
    if (range_err !== 1'b1) begin n_fail++; $display("FAIL rerr_flag: got %b, expected 1", range_err); end
    check_end("rerr", 0, 32'd0);
  endtask

  task automatic test_abort();
    int acc = 0, d0;
    push_range(0, 100);
    bus.out_ready = 1'b1;
    d0 = done_seen;
    do_start(12'd0, 12'd100);
    for (int k = 0; k < 200 && acc < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) acc++;
    end
    @(posedge clk); #1;
    abort = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({aborted, bus.out_valid, busy} !== 3'b100) begin
      n_fail++; $display("FAIL abort_pulse: aborted/valid/busy=%b, expected 100", {aborted, bus.out_valid, busy});
    end
    exp_q.delete();
    repeat (4) @(negedge clk);
    n_tests++;
    if (aborted !== 1'b0 || done_seen != d0) begin
      n_fail++; $display("FAIL abort_after: aborted=%b done_pulses=%0d, expected 0 0", aborted, done_seen - d0);
    end
    check_end("abort", 10, exp_sig);
  endtask

  task automatic test_reset_midscan();
    push_range(0, 50);
    do_start(12'd0, 12'd50);
    repeat (8) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.out_valid, busy, done, aborted} !== 4'b0 || word_count !== '0 ||
        signature !== 32'd0 || bus.raddr !== '0) begin
      n_fail++; $display("FAIL rst_mid: valid=%b busy=%b cnt=%0d sig=%h raddr=%h, expected 0",
                         bus.out_valid, busy, word_count, signature, bus.raddr);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = DATA_W'(a);
    bus.out_ready = 1'b1;
    test_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    test_scan_basic();
    test_single_word();
    test_top_of_memory();
    test_backpressure();
    test_range_err();
    test_abort();
    test_scan_basic();
    test_reset_midscan();
    test_scan_basic();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
